// File: rtl/eth_test_pkg.sv
// Shared definitions for the 10GBASE-R loopback test sequencer.
//   state_e     : FSM state encoding (4-bit)
//   fail_code_t : fail reason reported on fail_code
//   DEF_*       : default values for the sequencer timing parameters
//   is_active   : states in which a test is considered in progress
//   is_busy     : states other than the idle/result states
package eth_test_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_LINK = 4'd1,
        ST_SETTLE    = 4'd2,
        ST_CLEAR     = 4'd3,
        ST_RUN       = 4'd4,
        ST_DRAIN     = 4'd5,
        ST_REPORT    = 4'd6,
        ST_PASS      = 4'd7,
        ST_FAIL      = 4'd8
    } state_e;

    typedef logic [1:0] fail_code_t;

    localparam fail_code_t FC_NONE         = 2'd0;
    localparam fail_code_t FC_DATA         = 2'd1;
    localparam fail_code_t FC_LINK_LOST    = 2'd2;
    localparam fail_code_t FC_LINK_TIMEOUT = 2'd3;

    localparam int unsigned DEF_CNT_W         = 32;
    localparam logic [31:0] DEF_LINK_TIMEOUT  = 32'd156250000;
    localparam logic [31:0] DEF_SETTLE_CYCLES = 32'd1024;
    localparam logic [31:0] DEF_DRAIN_CYCLES  = 32'd256;

    function automatic logic is_active(input state_e s);
        return s inside {ST_WAIT_LINK, ST_SETTLE, ST_CLEAR, ST_RUN, ST_DRAIN};
    endfunction

    function automatic logic is_busy(input state_e s);
        return !(s inside {ST_IDLE, ST_PASS, ST_FAIL});
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for an asynchronous level input.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, clears both flops
//   d_i   : asynchronous input
//   q_o   : synchronized output (two clk_i edges of latency)
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/eth_test_sequencer.sv
// Sequencer for one 10GBASE-R loopback test run: waits for PMA lock, lets
// the link settle, clears the checker, enables the generator for run_len
// cycles, drains in-flight traffic and reports pass/fail.
//   clk, reset                : clock, asynchronous active-high reset
//   start, stop               : one-cycle run begin / abort pulses
//   run_len                   : run length in cycles (0 treated as 1)
//   tx_pma_ready, rx_pma_ready: asynchronous PMA lock indications
//   mon_err_in                : checker error strobe
//   gen_enable, mon_clear     : generator enable, one-cycle checker clear
//   mon_active, mon_done      : test in progress, one-cycle end pulse
//   mon_error, fail_code      : sticky fail flag and reason
//   err_count                 : saturating count of counted errors
//   busy                      : FSM not in IDLE/PASS/FAIL
module eth_test_sequencer
    import eth_test_pkg::*;
#(
    parameter int unsigned      CNT_W         = DEF_CNT_W,
    parameter logic [CNT_W-1:0] LINK_TIMEOUT  = CNT_W'(DEF_LINK_TIMEOUT),
    parameter logic [CNT_W-1:0] SETTLE_CYCLES = CNT_W'(DEF_SETTLE_CYCLES),
    parameter logic [CNT_W-1:0] DRAIN_CYCLES  = CNT_W'(DEF_DRAIN_CYCLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] run_len,
    input  logic             tx_pma_ready,
    input  logic             rx_pma_ready,
    input  logic             mon_err_in,
    output logic             gen_enable,
    output logic             mon_clear,
    output logic             mon_active,
    output logic             mon_done,
    output logic             mon_error,
    output logic [1:0]       fail_code,
    output logic [15:0]      err_count,
    output logic             busy
);

    logic tx_rdy_s;
    logic rx_rdy_s;
    logic link;

    sync_2ff u_sync_tx (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (tx_pma_ready),
        .q_o   (tx_rdy_s)
    );

    sync_2ff u_sync_rx (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   (rx_pma_ready),
        .q_o   (rx_rdy_s)
    );

    assign link = tx_rdy_s & rx_rdy_s;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             mon_error_q, mon_error_d;
    fail_code_t       fail_code_q, fail_code_d;
    logic [15:0]      err_count_q, err_count_d;
    logic             gen_enable_q, mon_clear_q, mon_active_q, mon_done_q, busy_q;
    logic             expired;

    // A phase loaded with N ends on the cycle the counter reads 1, so the
    // phase occupies exactly N cycles.
    assign expired = (cnt_q <= CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        len_d       = len_q;
        mon_error_d = mon_error_q;
        fail_code_d = fail_code_q;
        err_count_d = err_count_q;

        // Evaluated before the state case so a link loss in the same cycle
        // overrides the data-error code.
        if ((state_q == ST_RUN || state_q == ST_DRAIN) && mon_err_in) begin
            if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
            end
            mon_error_d = 1'b1;
            if (fail_code_q == FC_NONE) begin
                fail_code_d = FC_DATA;
            end
        end

        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start) begin
                    len_d       = (run_len == '0) ? CNT_W'(1) : run_len;
                    mon_error_d = 1'b0;
                    fail_code_d = FC_NONE;
                    err_count_d = '0;
                    cnt_d       = LINK_TIMEOUT;
                    state_d     = ST_WAIT_LINK;
                end
            end
            ST_WAIT_LINK: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (link) begin
                    cnt_d   = SETTLE_CYCLES;
                    state_d = ST_SETTLE;
                end else if (expired) begin
                    mon_error_d = 1'b1;
                    fail_code_d = FC_LINK_TIMEOUT;
                    state_d     = ST_REPORT;
                end
            end
            ST_SETTLE: begin
                if (!link) begin
                    cnt_d   = LINK_TIMEOUT;
                    state_d = ST_WAIT_LINK;
                end else if (stop) begin
                    state_d = ST_IDLE;
                end else if (expired) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d   = len_q;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!link) begin
                    mon_error_d = 1'b1;
                    fail_code_d = FC_LINK_LOST;
                    state_d     = ST_REPORT;
                end else if (stop || expired) begin
                    cnt_d   = DRAIN_CYCLES;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!link) begin
                    mon_error_d = 1'b1;
                    fail_code_d = FC_LINK_LOST;
                    state_d     = ST_REPORT;
                end else if (expired) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                state_d = mon_error_q ? ST_FAIL : ST_PASS;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-state outputs are registered from the next state so they line up
    // with the state register without any input-to-output combinational path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            len_q        <= '0;
            mon_error_q  <= 1'b0;
            fail_code_q  <= FC_NONE;
            err_count_q  <= '0;
            gen_enable_q <= 1'b0;
            mon_clear_q  <= 1'b0;
            mon_active_q <= 1'b0;
            mon_done_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            mon_error_q  <= mon_error_d;
            fail_code_q  <= fail_code_d;
            err_count_q  <= err_count_d;
            gen_enable_q <= (state_d == ST_RUN);
            mon_clear_q  <= (state_d == ST_CLEAR);
            mon_active_q <= is_active(state_d);
            mon_done_q   <= (state_d == ST_REPORT);
            busy_q       <= is_busy(state_d);
        end
    end

    assign gen_enable = gen_enable_q;
    assign mon_clear  = mon_clear_q;
    assign mon_active = mon_active_q;
    assign mon_done   = mon_done_q;
    assign mon_error  = mon_error_q;
    assign fail_code  = fail_code_q;
    assign err_count  = err_count_q;
    assign busy       = busy_q;

endmodule
